// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single registered memory request channel.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic   grant_i, grant_d;
    logic   fetch_first;

`ifdef ARB_STARVE_GUARD_EN
    // Counts data grants that were taken while fetch was also waiting.
    logic [3:0] starve_cnt_reg, starve_cnt_next;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (grant_i) begin
            starve_cnt_next = 4'd0;
        end else if (grant_d && i_req) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= 4'd0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    assign fetch_first = (starve_cnt_reg >= 4'(STARVE_LIMIT));
`else
    // Strict data priority; a zero limit would mean fetch always wins.
    assign fetch_first = (STARVE_LIMIT == 0);
`endif

    always_comb begin
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (d_req && !(i_req && fetch_first)) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                end else if (i_req) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign i_gnt = grant_i;
    assign d_gnt = grant_d;
    assign busy  = (state_reg != IDLE);

    // m_* hold their last command after completion; only m_req drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_be     <= 4'b0000;
            m_addr   <= 32'd0;
            m_wdata  <= 32'd0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= 32'd0;
            d_rdata  <= 32'd0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (grant_d) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_be    <= d_be;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end else if (grant_i) begin
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_be    <= 4'b1111;
                m_addr  <= i_addr;
                m_wdata <= 32'd0;
            end else if (state_reg != IDLE && m_ack) begin
                m_req <= 1'b0;
                if (state_reg == BUSY_I) begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= m_rdata;
                end else begin
                    d_rvalid <= 1'b1;
                    if (!m_we) begin
                        d_rdata <= m_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle,
// plus literal expectations for the key latency, ordering and reset scenarios.
module tb_mem_arbiter;

    localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we, m_ack;
    logic [3:0]  d_be;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, busy;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_be;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // 0 = nobody, 1 = fetch, 2 = data
    function automatic int pick(input logic ir, input logic dr, input int st);
        if (ir && dr) return (GUARD && st >= LIMIT) ? 1 : 2;
        if (dr) return 2;
        if (ir) return 1;
        return 0;
    endfunction

    // ---------------- transaction-level model ----------------
    int          owner;
    int          starve;
    logic        c_we, e_irv, e_drv;
    logic [3:0]  c_be;
    logic [31:0] c_addr, c_wdata, e_irdata, e_drdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= 0; starve <= 0;
            c_we <= 1'b0; c_be <= 4'h0; c_addr <= '0; c_wdata <= '0;
            e_irv <= 1'b0; e_drv <= 1'b0; e_irdata <= '0; e_drdata <= '0;
        end else begin
            e_irv <= 1'b0;
            e_drv <= 1'b0;
            if (owner == 0) begin
                case (pick(i_req, d_req, starve))
                    2: begin
                        owner <= 2; c_we <= d_we; c_be <= d_be; c_addr <= d_addr; c_wdata <= d_wdata;
                        if (i_req) starve <= starve + 1;
                    end
                    1: begin
                        owner <= 1; c_we <= 1'b0; c_be <= 4'hF; c_addr <= i_addr; c_wdata <= '0;
                        starve <= 0;
                    end
                    default: ;
                endcase
            end else if (m_ack) begin
                owner <= 0;
                if (owner == 1) begin
                    e_irv <= 1'b1; e_irdata <= m_rdata;
                end else begin
                    e_drv <= 1'b1;
                    if (!c_we) e_drdata <= m_rdata;
                end
            end
        end
    end

    // ---------------- compare + monitor ----------------
    bit   i_taken, d_taken;
    int   glog[$];
    int   gi_cyc, drv_cyc, we_cnt, drv_cnt;

    always @(negedge clk) begin
        if (rst_n) begin
            int p;
            p = pick(i_req, d_req, starve);
            chk("i_gnt",    32'(i_gnt),    32'(owner == 0 && p == 1));
            chk("d_gnt",    32'(d_gnt),    32'(owner == 0 && p == 2));
            chk("busy",     32'(busy),     32'(owner != 0));
            chk("m_req",    32'(m_req),    32'(owner != 0));
            chk("m_we",     32'(m_we),     32'(c_we));
            chk("m_be",     32'(m_be),     32'(c_be));
            chk("m_addr",   m_addr,        c_addr);
            chk("m_wdata",  m_wdata,       c_wdata);
            chk("i_rvalid", 32'(i_rvalid), 32'(e_irv));
            chk("d_rvalid", 32'(d_rvalid), 32'(e_drv));
            chk("i_rdata",  i_rdata,       e_irdata);
            chk("d_rdata",  d_rdata,       e_drdata);
            if (i_gnt) begin
                i_taken = 1'b1; glog.push_back(1);
                if (gi_cyc < 0) gi_cyc = cyc;
            end
            if (d_gnt) begin
                d_taken = 1'b1; glog.push_back(2);
            end
            if (d_rvalid) begin drv_cyc = cyc; drv_cnt++; end
            if (m_req && m_we && m_be == 4'b0011) we_cnt++;
            if (i_rvalid) $display("txn fetch  cycle=%0d rdata=%h", cyc, i_rdata);
            if (d_rvalid) $display("txn data   cycle=%0d we=%0b rdata=%h", cyc, m_we, d_rdata);
        end
    end

    // ---------------- requesters and memory responder ----------------
    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    logic [31:0] fq[$];
    dreq_t       dq[$];
    bit          auto_req = 1'b0;
    bit          auto_ack = 1'b0;
    int          ack_lat  = 0;
    int          wait_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_req) begin
                if (i_taken && fq.size() != 0) void'(fq.pop_front());
                if (d_taken && dq.size() != 0) void'(dq.pop_front());
                i_req  = (fq.size() != 0);
                i_addr = i_req ? fq[0] : 32'd0;
                d_req  = (dq.size() != 0);
                if (d_req) begin
                    d_we = dq[0].we; d_be = dq[0].be; d_addr = dq[0].addr; d_wdata = dq[0].wdata;
                end else begin
                    d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
                end
            end
            i_taken = 1'b0;
            d_taken = 1'b0;
            if (auto_ack) begin
                if (m_ack) begin
                    m_ack = 1'b0; m_rdata = '1;
                end else if (m_req) begin
                    if (wait_cnt >= ack_lat) begin
                        m_ack = 1'b1; m_rdata = mem_word(m_addr); wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    task automatic wait_idle(input int budget, input string name);
        bit done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            done = (fq.size() == 0 && dq.size() == 0 && !i_req && !d_req && !busy
                    && !i_rvalid && !d_rvalid);
        end
        chk(name, 32'(done), 32'd1);
        auto_req = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    int exp_order[6];

    initial begin
        rst_n = 1'b0;
        i_req = 0; d_req = 0; d_we = 0; d_be = 0; m_ack = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = '1;
        gi_cyc = -1; drv_cyc = -2; we_cnt = 0; drv_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_be", 32'(m_be), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        rst_n = 1'b1;

        // fetch only, ack in the first busy cycle
        step();
        i_req = 1; i_addr = 32'h100;
        @(negedge clk);
        chk("s1_i_gnt_c0", 32'(i_gnt), 32'd1);
        chk("s1_d_gnt_c0", 32'(d_gnt), 32'd0);
        step();
        i_req = 0; i_addr = 0; m_ack = 1; m_rdata = 32'h0050_0093;
        @(negedge clk);
        chk("s1_m_req_c1", 32'(m_req), 32'd1);
        chk("s1_busy_c1", 32'(busy), 32'd1);
        chk("s1_m_addr_c1", m_addr, 32'h100);
        chk("s1_m_be_c1", 32'(m_be), 32'hF);
        step();
        m_ack = 0; m_rdata = '1;
        @(negedge clk);
        chk("s1_i_rvalid_c2", 32'(i_rvalid), 32'd1);
        chk("s1_i_rdata_c2", i_rdata, 32'h0050_0093);
        chk("s1_m_req_c2", 32'(m_req), 32'd0);
        chk("s1_busy_c2", 32'(busy), 32'd0);
        step();
        @(negedge clk);
        chk("s1_i_rvalid_c3", 32'(i_rvalid), 32'd0);
        chk("s1_i_rdata_hold", i_rdata, 32'h0050_0093);

        // contended: data load wins, fetch granted on the d_rvalid cycle
        auto_ack = 1; ack_lat = 1;
        fq.push_back(32'h300);
        dq.push_back('{we: 1'b0, be: 4'hF, addr: 32'h2000, wdata: 32'h0});
        glog.delete(); gi_cyc = -1;
        auto_req = 1;
        wait_idle(100, "s2_timeout");
        chk("s2_first_grant", 32'(glog.size() > 0 ? glog[0] : 0), 32'd2);
        chk("s2_second_grant", 32'(glog.size() > 1 ? glog[1] : 0), 32'd1);
        chk("s2_gnt_on_rvalid", 32'(gi_cyc), 32'(drv_cyc));
        chk("s2_d_rdata", d_rdata, 32'hA5A5_2000);

        // store with three wait cycles
        ack_lat = 3; we_cnt = 0; drv_cnt = 0;
        dq.push_back('{we: 1'b1, be: 4'b0011, addr: 32'h2004, wdata: 32'hDEAD_BEEF});
        auto_req = 1;
        wait_idle(100, "s3_timeout");
        chk("s3_we_cycles", 32'(we_cnt), 32'd4);
        chk("s3_d_rvalid_pulses", 32'(drv_cnt), 32'd1);
        chk("s3_d_rdata_kept", d_rdata, 32'hA5A5_2000);

        // both ports continuously requesting
        ack_lat = 0;
        for (int k = 0; k < 8; k++)
            dq.push_back('{we: 1'b0, be: 4'hF, addr: 32'h3000 + 32'(4 * k), wdata: 32'h0});
        for (int k = 0; k < 3; k++) fq.push_back(32'h400 + 32'(4 * k));
        glog.delete();
        exp_order = GUARD ? '{2, 2, 2, 2, 1, 2} : '{2, 2, 2, 2, 2, 2};
        auto_req = 1;
        wait_idle(400, "s4_timeout");
        for (int k = 0; k < 6; k++)
            chk($sformatf("s4_order_%0d", k), 32'(glog.size() > k ? glog[k] : 0), 32'(exp_order[k]));

        // reset while a data load is outstanding
        auto_ack = 0; m_ack = 0;
        step();
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h4000;
        @(negedge clk);
        chk("s5_d_gnt", 32'(d_gnt), 32'd1);
        step();
        d_req = 0;
        @(negedge clk);
        chk("s5_busy_before", 32'(busy), 32'd1);
        step();
        rst_n = 0;
        #1;
        chk("s5_rst_m_req", 32'(m_req), 32'd0);
        chk("s5_rst_busy", 32'(busy), 32'd0);
        chk("s5_rst_m_addr", m_addr, 32'd0);
        step();
        rst_n = 1; m_ack = 1; m_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("s5_busy_ack", 32'(busy), 32'd0);
        step();
        m_ack = 0; m_rdata = '1;
        @(negedge clk);
        chk("s5_no_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("s5_d_rdata", d_rdata, 32'd0);
        step();
        i_req = 1; i_addr = 32'h500;
        @(negedge clk);
        chk("s5_i_gnt", 32'(i_gnt), 32'd1);
        step();
        i_req = 0; wait_cnt = 0; ack_lat = 0; auto_ack = 1;
        wait_idle(50, "s5_timeout");
        chk("s5_i_rdata", i_rdata, 32'hA5A5_0500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning max consecutive data grants while fetch waits (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port i_req  input  1  fetch request; held with i_addr stable until i_gnt.
REQ-005 SHALL have port i_addr  input  32  fetch address.
REQ-006 SHALL have port i_gnt  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port i_rvalid  output  1  one-cycle pulse, i_rdata valid.
REQ-008 SHALL have port i_rdata  output  32  fetched word.
REQ-009 SHALL have port d_req  input  1  load/store request; held with d_* inputs stable until d_gnt.
REQ-010 SHALL have ports d_we  input  1, d_be  input  4, d_addr  input  32, d_wdata  input  32: write enable, byte enables, address, store data.
REQ-011 SHALL have ports d_gnt  output  1, d_rvalid  output  1, d_rdata  output  32, mirroring the fetch port.
REQ-012 SHALL have ports m_req  output  1, m_we  output  1, m_be  output  4, m_addr  output  32, m_wdata  output  32: shared memory request, all registered.
REQ-013 SHALL have ports m_ack  input  1, m_rdata  input  32: memory completion, read data valid with m_ack.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE; drives datapath stall.

Function
REQ-015 SHALL implement states IDLE, BUSY_I, BUSY_D.
REQ-016 In IDLE with any request, SHALL select one winner, assert its gnt combinationally that cycle, register its command into m_*, set m_req=1, and move to BUSY_I/BUSY_D.
REQ-017 Fetch winner SHALL drive m_we=0, m_be=4'b1111, m_wdata=0.
REQ-018 gnt SHALL be asserted only in IDLE and to at most one requester per cycle.
REQ-019 In BUSY_x, m_req and m_* SHALL hold until the cycle m_ack=1; next edge SHALL clear m_req, capture m_rdata into x_rdata (reads only), pulse x_rvalid for one cycle, and return to IDLE.
REQ-020 Data writes SHALL also pulse d_rvalid as completion; d_rdata SHALL keep its previous value.
REQ-021 Latency: request in IDLE cycle 0, m_req high from cycle 1; m_ack in cycle k gives rvalid in cycle k+1, with the next grant possible in cycle k+1.
REQ-022 m_ack while IDLE SHALL be ignored.
REQ-023 x_rdata SHALL hold its value between rvalid pulses.
REQ-024 Base priority: data over fetch when both request in IDLE.

Reset
REQ-025 On rst_n=0, SHALL immediately go to IDLE with m_req=0, m_we=0, m_be=0, m_addr=0, m_wdata=0, i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0, starvation counter=0.
REQ-026 Reset mid-transaction SHALL abandon it with no rvalid; an m_ack for it after reset SHALL be ignored.

Configuration
REQ-027 Macro ARB_STARVE_GUARD_EN defined: a 4-bit counter SHALL increment on each data grant while i_req=1 and clear on any fetch grant; at count==STARVE_LIMIT, fetch SHALL win the next contended grant.
REQ-028 Macro undefined: no counter; strict data priority always.

Verification
REQ-029 Fetch only, i_addr=0x100, m_ack in cycle 1 with m_rdata=0x00500093 -> i_gnt cycle 0, m_req cycles 1 only, i_rvalid cycle 2, i_rdata=0x00500093, busy cycles 1.
REQ-030 Both request in IDLE, data load 0x2000 -> d_gnt first; after data completion, i_gnt on the cycle d_rvalid pulses.
REQ-031 Store d_addr=0x2004, d_be=4'b0011, d_wdata=0xDEADBEEF, m_ack after 3 wait cycles -> m_we=1, m_be=0011 held 4 cycles, d_rvalid pulse, d_rdata unchanged.
REQ-032 With ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, d_req and i_req continuously high -> grant order D,D,D,D,I,D,...; without macro -> D only.
REQ-033 rst_n low while BUSY_D, then m_ack after release -> no d_rvalid, state IDLE, m_req=0, next i_req granted normally.
